// File: rtl/muldiv_rs_issue_pkg.sv
// muldiv_pkg: shared types and constants for the mul/div reservation station.
//   CTRL_MUL / CTRL_DIV : the only function codes the station accepts
//   fsm_state_e         : issue controller states
//   rs_entry_t          : storage layout of one station entry
// The entry struct is sized by MD_XLEN / MD_TAG_W; the XLEN / TAG_W module
// parameters default to these and must be kept equal to them.
package muldiv_pkg;

  localparam int MD_XLEN  = 32;
  localparam int MD_TAG_W = 5;

  localparam logic [3:0] CTRL_MUL = 4'b0010;
  localparam logic [3:0] CTRL_DIV = 4'b0011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fsm_state_e;

  typedef struct packed {
    logic                busy;
    logic                issued;
    logic [3:0]          ctrl;
    logic [MD_TAG_W-1:0] rd_rob;
    logic                qj_pend;
    logic [MD_TAG_W-1:0] qj;
    logic [MD_XLEN-1:0]  vj;
    logic                qk_pend;
    logic [MD_TAG_W-1:0] qk;
    logic [MD_XLEN-1:0]  vk;
  } rs_entry_t;

  function automatic logic ctrl_legal(input logic [3:0] c);
    return (c == CTRL_MUL) || (c == CTRL_DIV);
  endfunction

endpackage

// File: rtl/muldiv_rs_issue_if.sv
// muldiv_rs_issue_if: dispatch-side alloc handshake plus the start/done
// handshake towards the shared mul/div unit.
//   master : the reservation station (accepts allocs, drives fu_*, takes fu_done)
//   slave  : the environment (dispatch stage and the functional unit)
interface muldiv_rs_issue_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             alloc_valid;
  logic             alloc_ready;
  logic [3:0]       alloc_ctrl;
  logic [TAG_W-1:0] alloc_rd_rob;
  logic             alloc_qj_vld;
  logic [TAG_W-1:0] alloc_qj;
  logic [XLEN-1:0]  alloc_vj;
  logic             alloc_qk_vld;
  logic [TAG_W-1:0] alloc_qk;
  logic [XLEN-1:0]  alloc_vk;

  logic             fu_data_ready;
  logic [XLEN-1:0]  fu_x;
  logic [XLEN-1:0]  fu_y;
  logic [3:0]       fu_ctrl;
  logic [TAG_W-1:0] fu_save_no;
  logic [TAG_W-1:0] fu_rd_rob;
  logic             fu_done;

  modport master (
    input  alloc_valid, alloc_ctrl, alloc_rd_rob,
           alloc_qj_vld, alloc_qj, alloc_vj,
           alloc_qk_vld, alloc_qk, alloc_vk,
    output alloc_ready,
    output fu_data_ready, fu_x, fu_y, fu_ctrl, fu_save_no, fu_rd_rob,
    input  fu_done
  );

  modport slave (
    output alloc_valid, alloc_ctrl, alloc_rd_rob,
           alloc_qj_vld, alloc_qj, alloc_vj,
           alloc_qk_vld, alloc_qk, alloc_vk,
    input  alloc_ready,
    input  fu_data_ready, fu_x, fu_y, fu_ctrl, fu_save_no, fu_rd_rob,
    output fu_done
  );
endinterface

// File: rtl/muldiv_rs_issue_rs_entry.sv
// rs_entry: one reservation-station slot.
//   wr_*        : alloc write (wr_en already qualified by the top)
//   cdb_*       : result broadcast, snooped for pending operands
//   set_issued  : entry was picked for issue this cycle
//   free_en     : unit reported done for this entry
//   flush       : discard contents
//   busy/ready  : status for the top's pickers; ctrl/rd_rob/vj/vk for issue
module rs_entry
  import muldiv_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int TAG_W = MD_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [3:0]       wr_ctrl,
  input  logic [TAG_W-1:0] wr_rd_rob,
  input  logic             wr_qj_vld,
  input  logic [TAG_W-1:0] wr_qj,
  input  logic [XLEN-1:0]  wr_vj,
  input  logic             wr_qk_vld,
  input  logic [TAG_W-1:0] wr_qk,
  input  logic [XLEN-1:0]  wr_vk,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_rob,
  input  logic [XLEN-1:0]  cdb_value,
  input  logic             set_issued,
  input  logic             free_en,
  input  logic             flush,
  output logic             busy,
  output logic             ready,
  output logic [3:0]       ctrl,
  output logic [TAG_W-1:0] rd_rob,
  output logic [XLEN-1:0]  vj,
  output logic [XLEN-1:0]  vk
);

  rs_entry_t ent;

  // Snoop hits on stored operands, and bypass hits on the op being written.
  logic hit_j, hit_k, byp_j, byp_k;
  assign hit_j = cdb_valid & ent.busy & ent.qj_pend & (cdb_rob == ent.qj);
  assign hit_k = cdb_valid & ent.busy & ent.qk_pend & (cdb_rob == ent.qk);
  assign byp_j = cdb_valid & wr_qj_vld & (cdb_rob == wr_qj);
  assign byp_k = cdb_valid & wr_qk_vld & (cdb_rob == wr_qk);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent <= '0;
    end else if (flush) begin
      ent.busy    <= 1'b0;
      ent.issued  <= 1'b0;
      ent.qj_pend <= 1'b0;
      ent.qk_pend <= 1'b0;
    end else if (wr_en) begin
      ent.busy    <= 1'b1;
      ent.issued  <= 1'b0;
      ent.ctrl    <= wr_ctrl;
      ent.rd_rob  <= wr_rd_rob;
      ent.qj_pend <= wr_qj_vld & ~byp_j;
      ent.qj      <= wr_qj;
      ent.vj      <= byp_j ? cdb_value : wr_vj;
      ent.qk_pend <= wr_qk_vld & ~byp_k;
      ent.qk      <= wr_qk;
      ent.vk      <= byp_k ? cdb_value : wr_vk;
    end else begin
      // A written entry is never busy, so wr_en cannot collide with free/issue.
      if (free_en) begin
        ent.busy   <= 1'b0;
        ent.issued <= 1'b0;
      end else if (set_issued) begin
        ent.issued <= 1'b1;
      end
      if (hit_j) begin
        ent.vj      <= cdb_value;
        ent.qj_pend <= 1'b0;
      end
      if (hit_k) begin
        ent.vk      <= cdb_value;
        ent.qk_pend <= 1'b0;
      end
    end
  end

  assign busy   = ent.busy;
  assign ready  = ent.busy & ~ent.qj_pend & ~ent.qk_pend & ~ent.issued;
  assign ctrl   = ent.ctrl;
  assign rd_rob = ent.rd_rob;
  assign vj     = ent.vj;
  assign vk     = ent.vk;

endmodule

// File: rtl/muldiv_rs_issue.sv
// muldiv_rs_issue: reservation station + issue controller for the shared
// mul/div unit.
//   clk, rst   : clock, async active-high reset
//   bus        : alloc handshake from dispatch, start/done handshake to the unit
//   cdb_*      : result broadcast used to wake pending operands
//   flush      : discard every entry; an in-flight op is drained and dropped
//   occupancy  : number of busy entries
// One op is in the unit at a time: IDLE picks, ISSUE pulses start, WAIT holds
// the operands until done, DRAIN swallows the done of a flushed op.
module muldiv_rs_issue
  import muldiv_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int XLEN    = MD_XLEN,
  parameter int TAG_W   = MD_TAG_W
) (
  input  logic                clk,
  input  logic                rst,
  muldiv_rs_issue_if.master   bus,
  input  logic                cdb_valid,
  input  logic [TAG_W-1:0]    cdb_rob,
  input  logic [XLEN-1:0]     cdb_value,
  input  logic                flush,
  output logic [3:0]          occupancy
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [ENTRIES-1:0]             busy, ready, wr_en, set_iss, free_en;
  logic [ENTRIES-1:0][3:0]        ent_ctrl;
  logic [ENTRIES-1:0][TAG_W-1:0]  ent_rd_rob;
  logic [ENTRIES-1:0][XLEN-1:0]   ent_vj, ent_vk;

  logic [1:0]       state, state_nx;
  logic [IDX_W-1:0] lat_idx;
  logic [XLEN-1:0]  x_q, y_q;
  logic [3:0]       ctrl_q;
  logic [TAG_W-1:0] rd_rob_q;

  // Lowest-index pickers (descending scan so the last hit is the lowest).
  logic             free_any, ready_any;
  logic [IDX_W-1:0] free_idx, ready_idx;
  logic [3:0]       occ_c;

  always_comb begin
    free_any  = 1'b0;
    free_idx  = '0;
    ready_any = 1'b0;
    ready_idx = '0;
    occ_c     = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (ready[i]) begin
        ready_any = 1'b1;
        ready_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < ENTRIES; i++) occ_c = occ_c + {3'b000, busy[i]};
  end

  assign occupancy       = occ_c;
  // Driven from entry state only, so a same-cycle done cannot open a slot.
  assign bus.alloc_ready = free_any;

  logic alloc_fire, issue_go, done_free;
  assign alloc_fire = bus.alloc_valid & free_any & ctrl_legal(bus.alloc_ctrl) & ~flush;
  assign issue_go   = (state == ST_IDLE) & ready_any & ~flush;
  assign done_free  = (state == ST_WAIT) & bus.fu_done & ~flush;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    assign wr_en[i]   = alloc_fire & (free_idx == IDX_W'(i));
    assign set_iss[i] = issue_go & (ready_idx == IDX_W'(i));
    assign free_en[i] = done_free & (lat_idx == IDX_W'(i));

    rs_entry #(.XLEN(XLEN), .TAG_W(TAG_W)) u_ent (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en[i]),
      .wr_ctrl    (bus.alloc_ctrl),
      .wr_rd_rob  (bus.alloc_rd_rob),
      .wr_qj_vld  (bus.alloc_qj_vld),
      .wr_qj      (bus.alloc_qj),
      .wr_vj      (bus.alloc_vj),
      .wr_qk_vld  (bus.alloc_qk_vld),
      .wr_qk      (bus.alloc_qk),
      .wr_vk      (bus.alloc_vk),
      .cdb_valid  (cdb_valid),
      .cdb_rob    (cdb_rob),
      .cdb_value  (cdb_value),
      .set_issued (set_iss[i]),
      .free_en    (free_en[i]),
      .flush      (flush),
      .busy       (busy[i]),
      .ready      (ready[i]),
      .ctrl       (ent_ctrl[i]),
      .rd_rob     (ent_rd_rob[i]),
      .vj         (ent_vj[i]),
      .vk         (ent_vk[i])
    );
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (issue_go) state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = flush ? ST_DRAIN : ST_WAIT;
      // A done arriving with the flush retires the op, so nothing is left to drain.
      ST_WAIT:  if (bus.fu_done) state_nx = ST_IDLE;
                else if (flush) state_nx = ST_DRAIN;
      ST_DRAIN: if (bus.fu_done) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      lat_idx  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      ctrl_q   <= '0;
      rd_rob_q <= '0;
    end else begin
      state <= state_nx;
      if (issue_go) begin
        lat_idx  <= ready_idx;
        x_q      <= ent_vj[ready_idx];
        y_q      <= ent_vk[ready_idx];
        ctrl_q   <= ent_ctrl[ready_idx];
        rd_rob_q <= ent_rd_rob[ready_idx];
      end
    end
  end

  // Operands come from the latch so they stay stable through WAIT.
  assign bus.fu_data_ready = (state == ST_ISSUE);
  assign bus.fu_x          = x_q;
  assign bus.fu_y          = y_q;
  assign bus.fu_ctrl       = ctrl_q;
  assign bus.fu_save_no    = TAG_W'(lat_idx);
  assign bus.fu_rd_rob     = rd_rob_q;

endmodule

// File: tb/tb_muldiv_rs_issue.sv
module tb_muldiv_rs_issue;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cdb_valid;
  logic [4:0]  cdb_rob;
  logic [31:0] cdb_value;
  logic        flush;
  logic [3:0]  occupancy;

  always #5 clk = ~clk;

  muldiv_rs_issue_if #(.XLEN(32), .TAG_W(5)) bus ();

  muldiv_rs_issue #(.ENTRIES(4), .XLEN(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cdb_valid (cdb_valid),
    .cdb_rob   (cdb_rob),
    .cdb_value (cdb_value),
    .flush     (flush),
    .occupancy (occupancy)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  ctrl;
    logic [4:0]  save_no;
    logic [4:0]  rd_rob;
  } iss_t;

  iss_t exp_q[$];
  iss_t e;
  int   total  = 0;
  int   bad    = 0;
  int   pulses = 0;

  // Scoreboard monitor: every start pulse must match the oldest expected issue.
  always @(negedge clk) begin
    if (!rst && bus.fu_data_ready) begin
      pulses++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected actual x=%0h y=%0h save=%0d rob=%0d required none",
                 bus.fu_x, bus.fu_y, bus.fu_save_no, bus.fu_rd_rob);
      end else begin
        e = exp_q.pop_front();
        if ({bus.fu_x, bus.fu_y, bus.fu_ctrl, bus.fu_save_no, bus.fu_rd_rob} !==
            {e.x, e.y, e.ctrl, e.save_no, e.rd_rob}) begin
          bad++;
          $display("FAIL issue_fields actual x=%0h y=%0h ctrl=%0h save=%0d rob=%0d required x=%0h y=%0h ctrl=%0h save=%0d rob=%0d",
                   bus.fu_x, bus.fu_y, bus.fu_ctrl, bus.fu_save_no, bus.fu_rd_rob,
                   e.x, e.y, e.ctrl, e.save_no, e.rd_rob);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input logic [31:0] x, input logic [31:0] y,
                              input logic [3:0] c, input logic [4:0] sn, input logic [4:0] rd);
    iss_t t;
    t.x = x; t.y = y; t.ctrl = c; t.save_no = sn; t.rd_rob = rd;
    exp_q.push_back(t);
  endtask

  task automatic alloc(input logic [3:0] c, input logic [4:0] rd,
                       input logic qjv, input logic [4:0] qj, input logic [31:0] vj,
                       input logic qkv, input logic [4:0] qk, input logic [31:0] vk);
    bus.alloc_valid  = 1'b1;
    bus.alloc_ctrl   = c;
    bus.alloc_rd_rob = rd;
    bus.alloc_qj_vld = qjv;
    bus.alloc_qj     = qj;
    bus.alloc_vj     = vj;
    bus.alloc_qk_vld = qkv;
    bus.alloc_qk     = qk;
    bus.alloc_vk     = vk;
    tick();
    bus.alloc_valid  = 1'b0;
  endtask

  task automatic cdb(input logic [4:0] rob, input logic [31:0] val);
    cdb_valid = 1'b1; cdb_rob = rob; cdb_value = val;
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic done_pulse();
    bus.fu_done = 1'b1;
    tick();
    bus.fu_done = 1'b0;
  endtask

  task automatic wait_pulses(input string nm, input int target, input int max_cyc);
    int n = 0;
    while (pulses < target && n < max_cyc) begin
      tick();
      n++;
    end
    check(nm, pulses, target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int p;
    rst = 1'b1;
    cdb_valid = 1'b0; cdb_rob = '0; cdb_value = '0; flush = 1'b0;
    bus.alloc_valid = 1'b0; bus.alloc_ctrl = '0; bus.alloc_rd_rob = '0;
    bus.alloc_qj_vld = 1'b0; bus.alloc_qj = '0; bus.alloc_vj = '0;
    bus.alloc_qk_vld = 1'b0; bus.alloc_qk = '0; bus.alloc_vk = '0;
    bus.fu_done = 1'b0;
    tick(); tick();
    check("rst_occ", occupancy, 0);
    check("rst_alloc_ready", bus.alloc_ready, 1);
    check("rst_start", bus.fu_data_ready, 0);
    check("rst_x", bus.fu_x, 0);
    rst = 1'b0;

    // 1: ready mul; alloc presented in cycle 0, start pulse in cycle 2
    expect_issue(6, 7, CTRL_MUL, 0, 3);
    alloc(CTRL_MUL, 3, 0, 0, 6, 0, 0, 7);
    check("t1_occ", occupancy, 1);
    check("t1_no_early", bus.fu_data_ready, 0);
    tick();
    check("t1_start", bus.fu_data_ready, 1);
    tick();
    check("t1_pulse_one_cycle", bus.fu_data_ready, 0);
    check("t1_x_held", bus.fu_x, 6);
    done_pulse();
    check("t1_freed", occupancy, 0);

    // 2: div waits for operand A from the CDB; done in IDLE ignored
    p = pulses;
    expect_issue(100, 5, CTRL_DIV, 0, 10);
    alloc(CTRL_DIV, 10, 1, 9, 0, 0, 0, 5);
    tick(); tick(); tick();
    check("t2_no_issue", pulses, p);
    done_pulse();
    check("t2_done_idle_ignored", occupancy, 1);
    cdb(9, 100);
    wait_pulses("t2_issue", p + 1, 6);
    tick();
    done_pulse();
    check("t2_freed", occupancy, 0);

    // 3: CDB bypass on the alloc cycle
    p = pulses;
    expect_issue(8, 2, CTRL_MUL, 0, 11);
    cdb_valid = 1'b1; cdb_rob = 4; cdb_value = 8;
    alloc(CTRL_MUL, 11, 1, 4, 0, 0, 0, 2);
    cdb_valid = 1'b0;
    tick();
    check("t3_bypass_start", bus.fu_data_ready, 1);
    check("t3_count", pulses, p);
    tick();
    done_pulse();

    // 4: fill the station, overflow and illegal allocs ignored
    p = pulses;
    expect_issue(1, 1, CTRL_MUL, 0, 12);
    alloc(CTRL_MUL, 12, 0, 0, 1, 0, 0, 1);
    alloc(CTRL_MUL, 13, 1, 20, 0, 0, 0, 2);
    alloc(CTRL_DIV, 14, 1, 20, 0, 0, 0, 3);
    alloc(CTRL_MUL, 15, 0, 0, 4, 1, 21, 0);
    check("t4_full_occ", occupancy, 4);
    check("t4_full_ready", bus.alloc_ready, 0);
    alloc(CTRL_MUL, 16, 0, 0, 5, 0, 0, 5);
    check("t4_overflow_ignored", occupancy, 4);
    check("t4_e0_issued", pulses, p + 1);
    bus.fu_done = 1'b1;
    #1;
    check("t4_ready_same_cycle", bus.alloc_ready, 0);
    tick();
    bus.fu_done = 1'b0;
    check("t4_ready_next_cycle", bus.alloc_ready, 1);
    check("t4_occ_after_done", occupancy, 3);
    alloc(4'b0101, 17, 0, 0, 1, 0, 0, 1);
    check("t4_illegal_ignored", occupancy, 3);
    do_reset();
    check("t4_reset_occ", occupancy, 0);

    // 5: entry 0 pending, 1 and 2 ready -> 1, then 2 after done, then 0 on CDB
    p = pulses;
    alloc(CTRL_MUL, 16, 1, 7, 0, 0, 0, 3);
    expect_issue(2, 3, CTRL_MUL, 1, 17);
    expect_issue(4, 5, CTRL_DIV, 2, 18);
    alloc(CTRL_MUL, 17, 0, 0, 2, 0, 0, 3);
    alloc(CTRL_DIV, 18, 0, 0, 4, 0, 0, 5);
    wait_pulses("t5_first", p + 1, 6);
    tick(); tick(); tick();
    check("t5_second_waits", pulses, p + 1);
    done_pulse();
    wait_pulses("t5_second", p + 2, 6);
    tick();
    done_pulse();
    expect_issue(9, 3, CTRL_MUL, 0, 16);
    cdb(7, 9);
    wait_pulses("t5_third", p + 3, 6);
    tick();
    done_pulse();
    check("t5_empty", occupancy, 0);

    // 6: flush in WAIT -> DRAIN swallows the next done; then rst mid-WAIT
    p = pulses;
    expect_issue(10, 20, CTRL_DIV, 0, 19);
    alloc(CTRL_DIV, 19, 0, 0, 10, 0, 0, 20);
    wait_pulses("t6_issue", p + 1, 6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_flush_occ", occupancy, 0);
    expect_issue(3, 4, CTRL_MUL, 0, 20);
    alloc(CTRL_MUL, 20, 0, 0, 3, 0, 0, 4);
    tick(); tick(); tick();
    check("t6_drain_no_issue", pulses, p + 1);
    done_pulse();
    check("t6_drain_done_discarded", occupancy, 1);
    wait_pulses("t6_after_drain", p + 2, 6);
    tick();
    rst = 1'b1;
    #1;
    check("t6_rst_start", bus.fu_data_ready, 0);
    check("t6_rst_x", bus.fu_x, 0);
    check("t6_rst_y", bus.fu_y, 0);
    check("t6_rst_ctrl", bus.fu_ctrl, 0);
    check("t6_rst_rob", bus.fu_rd_rob, 0);
    check("t6_rst_occ", occupancy, 0);
    check("t6_rst_alloc_ready", bus.alloc_ready, 1);
    tick();
    rst = 1'b0;
    tick(); tick();
    check("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
